tff_counter: RTL and testbench

Parametrised modulo-N up/down counter built from a bank of T flip-flop cells, each bit toggling when its computed next value differs from its current value. It is the multi-bit successor to the single-bit T flip-flop. It adds direction control, parallel load, a configurable modulus, a terminal-count flag and a wrap pulse. It sits wherever the design needs event counting or divide-by-N timing, with true and complement outputs for every bit.

---
 rtl/tff_counter_pkg.sv | 24 ++
 rtl/tff_cell.sv | 24 ++
 rtl/tff_counter.sv | 85 ++++++++
 tb/tb_tff_counter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tff_counter_pkg.sv
// Shared definitions for the modulo-N T flip-flop counter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package tff_counter_pkg;

  // Encodings of the up_dn input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_WIDTH = 16;

  // Largest count value (MODULUS-1), computed in int and then narrowed.
  // The result always fits MAX_WIDTH bits because MODULUS <= 2^MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] terminal_value(input int modulus);
    return MAX_WIDTH'(modulus - 1);
  endfunction

  // True when WIDTH and MODULUS describe a buildable counter.
  function automatic bit params_ok(input int width, input int modulus);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop cell with registered true and complement outputs.
// Latency: 1 clk from t to q/q_n.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), t (toggle), q, q_n.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q,
  output logic q_n
);

  // q_n gets its own flop so it is a true register, not an inverter on q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= 1'b0;
      q_n <= 1'b1;
    end else begin
      q   <= q ^ t;
      q_n <= ~(q ^ t);
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Modulo-MODULUS up/down counter with parallel load, built from T flip-flop cells.
// Latency: 1 clk from load/en to q/q_n; tc combinational; wrap/load_err lag 1 clk.
// Backpressure: none; every enabled edge is consumed.
// Ports: clk, reset (sync, active-high), en, up_dn, load, load_val -> q, q_n, tc, wrap, load_err.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_param_error
    $error("tff_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [MAX_WIDTH-1:0] TERM_FULL = terminal_value(MODULUS);
  localparam logic [WIDTH-1:0]     TERM      = TERM_FULL[WIDTH-1:0];

  wire  [WIDTH-1:0] q_cells;
  wire  [WIDTH-1:0] q_n_cells;
  logic [WIDTH-1:0] next_q;
  logic             load_in_range;

  // TERM equals MODULUS-1 at WIDTH bits, so <= TERM is the same as < MODULUS
  // without needing a WIDTH+1-bit compare.
  assign load_in_range = (load_val <= TERM);

  // Out-of-range states (only reachable via X) fall into the >= TERM branch
  // when counting up, so they wrap to 0; counting down they simply decrement.
  always_comb begin
    next_q = q_cells;
    if (reset) begin
      next_q = '0;
    end else if (load) begin
      next_q = load_in_range ? load_val : TERM;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        next_q = (q_cells >= TERM) ? '0 : q_cells + WIDTH'(1);
      end else begin
        next_q = (q_cells == '0) ? TERM : q_cells - WIDTH'(1);
      end
    end
  end

  // Each cell toggles exactly the bits that change.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (next_q[i] ^ q_cells[i]),
      .q     (q_cells[i]),
      .q_n   (q_n_cells[i])
    );
  end

  assign q   = q_cells;
  assign q_n = q_n_cells;

  assign tc = ~reset & en &
              (((up_dn == DIR_UP)   & (q_cells == TERM)) |
               ((up_dn == DIR_DOWN) & (q_cells == '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= tc & ~load;
      load_err <= load & ~load_in_range;
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         tc;
  logic         wrap;
  logic         load_err;

  int n_assert = 0;
  int n_fail   = 0;
  int mq       = 0;   // model count

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .q_n      (q_n),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: check tc before the edge, then all registered
  // outputs just after it against the arithmetic model.
  task automatic step(input bit r, input bit l, input int lv, input bit e, input bit ud);
    int  nq;
    bit  ntc, nwrap, nerr;
    logic [W-1:0] lv_bits;
    lv_bits  = lv[W-1:0];
    reset    = r;
    load     = l;
    load_val = lv_bits;
    en       = e;
    up_dn    = ud;
    #1;
    ntc = !r && e && (ud ? (mq == M - 1) : (mq == 0));
    chk("tc", {31'b0, tc}, {31'b0, ntc});
    nwrap = 1'b0;
    nerr  = 1'b0;
    if (r) begin
      nq = 0;
    end else if (l) begin
      if (lv < M) nq = lv;
      else begin
        nq   = M - 1;
        nerr = 1'b1;
      end
    end else if (e) begin
      nq    = ud ? (mq + 1) % M : (mq + M - 1) % M;
      nwrap = ntc;
    end else begin
      nq = mq;
    end
    @(posedge clk);
    #1;
    mq = nq;
    chk("q", {28'b0, q}, nq);
    chk("q_n", {28'b0, q_n}, (~nq) & 32'hF);
    chk("wrap", {31'b0, wrap}, {31'b0, nwrap});
    chk("load_err", {31'b0, load_err}, {31'b0, nerr});
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, 1);
    step(1, 1, 5, 1, 1);

    // up-count through two full wraps
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);

    // down-count from reset
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);

    // in-range load, out-of-range load, then idle to clear load_err
    step(0, 1, 7, 0, 1);
    step(0, 1, 12, 0, 1);
    step(0, 0, 0, 0, 1);

    // load beats en at the terminal value: no wrap
    step(0, 1, 9, 0, 1);
    step(0, 1, 3, 1, 1);

    // reset beats an out-of-range load
    step(1, 1, 12, 1, 1);

    // direction flip: 4,5,6,5,4
    step(0, 1, 4, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // hold at 3 with en low
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);

    // randomized traffic, including out-of-range loads
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 25) == 0, ($urandom % 6) == 0, int'($urandom % 16),
           ($urandom % 4) != 0, $urandom % 2 == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
